instruction_dispatch: RTL and testbench
=======================================

# instruction_dispatch

Write-side producer for the three Cherry instruction queues (DMA, arithmetic, cache). It accepts one decoded program bundle per cycle from the front end over a valid/ready handshake and groups up to four consecutive bundles. It then splits each group into its DMA, arithmetic and cache fields and issues one slot-aligned multi-entry write to all three queues. Slot k of every queue always comes from the same bundle, so the consumer units stay in lock-step.

## Interface
- TIMEOUT, 8: idle cycles with a partial group before a forced flush (≥1).
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  bundle present.
- in_ready  out  1  block can accept a bundle this cycle.
- in_instr  in  96  bundle. DMA field [95:18] (active bit [95]); arith field [17]; cache field [16:0] (active bit [16]).
- in_last  in  1  flush the group after this bundle.
- dma_full_soon  in  1  DMA queue within 4 entries of full.
- arith_full_soon  in  1  arithmetic queue within 4 entries of full.
- cache_full_soon  in  1  cache queue within 4 entries of full.
- q_we  out  1  write strobe, shared by all three queues.
- q_we_count  out  2  entries written minus 1.
- dma_dat_w  out  312  slot k at [78k+77:78k].
- arith_dat_w  out  4  slot k at [k].
- cache_dat_w  out  68  slot k at [17k+16:17k].

## Operation
- State machine FILL / WRITE. Reset state is FILL with cnt=0 and idle=0.
- Buffer: 4 slots of 96 bits. cnt is 0..4.
- in_ready = (state==FILL) && !reset. Accept = in_valid && in_ready.
- On accept in FILL:
  - The bundle is stored at slot cnt; cnt increments; idle clears.
  - Go to WRITE if the new cnt==4 or in_last=1.
- In FILL with cnt>0 and no accept, idle increments. When idle==TIMEOUT, go to WRITE.
- In FILL with cnt==0, idle holds at 0.
- In WRITE:
  - q_we = !(dma_full_soon | arith_full_soon | cache_full_soon).
  - While any full_soon is high, the block stalls in WRITE with q_we=0 and the buffer held.
  - On a cycle with q_we=1: cnt, idle and the buffer clear; next state is FILL.
- q_we_count = q_we ? cnt-1 : 0.
- Data outputs are driven directly from the buffer. Slots ≥cnt are all-zero, i.e. inactive entries.
- Field split per slot: dma = bits[95:18], arith = bit[17], cache = bits[16:0].
- Reset mid-operation (FILL or WRITE): the partial group is discarded. No q_we is issued.
- Reset values: in_ready=0 during reset, then 1; q_we=0, q_we_count=0, all data outputs 0.

## Timing
- Group completion on accept edge N → WRITE in cycle N+1 → q_we in that cycle if no full_soon. Latency from last accept to write is 1 cycle.
- One cycle with q_we=1 per group. in_ready is low for every WRITE cycle, including the q_we cycle. in_ready returns high the cycle after q_we.
- Back-to-back throughput is 4 bundles per 5 cycles.
- Timeout: the flush enters WRITE on the edge where idle reaches TIMEOUT. With TIMEOUT=8, q_we asserts in the 9th cycle after the last accept.
- in_last on the 4th bundle produces a single flush, not two.
- full_soon is sampled combinationally in WRITE only and ignored in FILL.

## Configuration
- DISPATCH_SQUASH_EN defined:
  - A bundle with bits[95], [17] and [16] all 0 completes the handshake but is not stored; cnt and idle are unchanged.
  - If such a bundle carries in_last and cnt>0, the block goes to WRITE. If cnt==0, no write occurs.
- Undefined: every accepted bundle is stored, including all-inactive bubbles.

## Test plan
- Four bundles on consecutive cycles, slot k with DMA field = k+1, full_soon all low → one q_we cycle 1 cycle after the 4th accept. q_we_count=3; dma_dat_w slots hold 1,2,3,4. in_ready=0 in that cycle.
- Two bundles with in_last on the 2nd → q_we_count=1; slots 2–3 of all outputs are 0; in_ready=1 the following cycle.
- One bundle then in_valid=0, TIMEOUT=8 → q_we in the 9th cycle after the accept; q_we_count=0.
- Group of 4 completes with cache_full_soon high for 5 cycles → q_we=0 and in_ready=0 for those 5 cycles; q_we=1 in the first cycle after release with data unchanged.
- DISPATCH_SQUASH_EN on: stream of active, bubble, active, bubble(in_last) → q_we_count=1, slots 0–1 hold the two active bundles. Macro off: same stream gives q_we_count=3.
- Reset asserted in a WRITE stall cycle → q_we stays 0; after release cnt=0, in_ready=1, and the next single in_last bundle gives q_we_count=0.

Source files
------------

// File: rtl/instruction_dispatch_if.sv
// Front-end bundle handshake plus the shared slot-aligned write port into the
// DMA / arithmetic / cache instruction queues.
interface instruction_dispatch_if;
  logic         in_valid;
  logic         in_ready;
  logic [95:0]  in_instr;
  logic         in_last;
  logic         dma_full_soon;
  logic         arith_full_soon;
  logic         cache_full_soon;
  logic         q_we;
  logic [1:0]   q_we_count;
  logic [311:0] dma_dat_w;
  logic [3:0]   arith_dat_w;
  logic [67:0]  cache_dat_w;

  modport master (
    output in_valid, in_instr, in_last,
    output dma_full_soon, arith_full_soon, cache_full_soon,
    input  in_ready, q_we, q_we_count, dma_dat_w, arith_dat_w, cache_dat_w
  );

  modport slave (
    input  in_valid, in_instr, in_last,
    input  dma_full_soon, arith_full_soon, cache_full_soon,
    output in_ready, q_we, q_we_count, dma_dat_w, arith_dat_w, cache_dat_w
  );
endinterface

// File: rtl/instruction_dispatch.sv
// Groups up to four bundles and issues one slot-aligned write to all three queues.
// Optional: DISPATCH_SQUASH_EN drops all-inactive bundles instead of storing them.
module instruction_dispatch #(
  parameter int TIMEOUT = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  instruction_dispatch_if.slave  bus
);
  localparam int NUM_SLOTS = 4;
  localparam int DMA_W     = 78;
  localparam int CACHE_W   = 17;
  localparam int IDLE_W    = $clog2(TIMEOUT + 1);

  typedef enum logic {FILL, WRITE} state_t;

  state_t                          state, state_nxt;
  logic [2:0]                      cnt, cnt_nxt;
  logic [IDLE_W-1:0]               idle, idle_nxt;
  logic [NUM_SLOTS-1:0][95:0]      slot_q;
  logic                            ready, accept, bubble, store, clear, we;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= FILL;
      cnt    <= '0;
      idle   <= '0;
      slot_q <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      idle  <= idle_nxt;
      if (clear)
        slot_q <= '0;
      else if (store)
        slot_q[cnt[1:0]] <= bus.in_instr;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idle_nxt  = idle;
    store     = 1'b0;
    clear     = 1'b0;
    we        = 1'b0;
    ready     = (state == FILL) && !reset;
    accept    = bus.in_valid && ready;
`ifdef DISPATCH_SQUASH_EN
    bubble    = !(bus.in_instr[95] | bus.in_instr[17] | bus.in_instr[16]);
`else
    bubble    = 1'b0;
`endif
    case (state)
      FILL: begin
        if (accept) begin
          if (!bubble) begin
            store    = 1'b1;
            cnt_nxt  = cnt + 3'd1;
            idle_nxt = '0;
            if (cnt == 3'd3 || bus.in_last) state_nxt = WRITE;
          end else if (bus.in_last && cnt != 3'd0) begin
            // a squashed in_last still closes a non-empty group
            state_nxt = WRITE;
          end
        end else if (cnt != 3'd0) begin
          idle_nxt = idle + IDLE_W'(1);
          if (idle_nxt == IDLE_W'(TIMEOUT)) state_nxt = WRITE;
        end
      end
      WRITE: begin
        we = !reset && !(bus.dma_full_soon | bus.arith_full_soon | bus.cache_full_soon);
        if (we) begin
          clear     = 1'b1;
          cnt_nxt   = '0;
          idle_nxt  = '0;
          state_nxt = FILL;
        end
      end
      default: state_nxt = FILL;
    endcase
  end

  assign bus.in_ready   = ready;
  assign bus.q_we       = we;
  assign bus.q_we_count = we ? (cnt[1:0] - 2'd1) : 2'd0;

  // unused slots are already zero because the buffer clears on every write
  for (genvar k = 0; k < NUM_SLOTS; k++) begin : g_slot
    assign bus.dma_dat_w[DMA_W*k +: DMA_W]       = reset ? '0 : slot_q[k][95:18];
    assign bus.arith_dat_w[k]                    = reset ? 1'b0 : slot_q[k][17];
    assign bus.cache_dat_w[CACHE_W*k +: CACHE_W] = reset ? '0 : slot_q[k][16:0];
  end
endmodule

// File: tb/tb_instruction_dispatch.sv
// Random + directed check of instruction_dispatch against a queue-based group model.
module tb_instruction_dispatch;
  localparam int TIMEOUT = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  instruction_dispatch_if bus();
  instruction_dispatch #(.TIMEOUT(TIMEOUT)) dut (.clk(clk), .reset(rst), .bus(bus));

  int vectors = 0;
  int miscompares = 0;

  // stimulus for the next cycle
  logic        vld, last, dfs, afs, cfs, rst_in;
  logic [95:0] instr;

  // observed outputs of the last stepped cycle
  logic         o_ready, o_we;
  logic [1:0]   o_wec;
  logic [311:0] o_dma;
  logic [3:0]   o_ar;
  logic [67:0]  o_ca;

  // reference model: the pending group as a queue
  logic [95:0] grp[$];
  int          m_idle;
  bit          m_flush;

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit is_bubble(input logic [95:0] b);
`ifdef DISPATCH_SQUASH_EN
    return !(b[95] | b[17] | b[16]);
`else
    return 1'b0;
`endif
  endfunction

  task automatic step();
    logic [311:0] ed;
    logic [3:0]   ea;
    logic [67:0]  ec;
    logic         er, ew;
    logic [1:0]   ewc;
    @(negedge clk);
    rst = rst_in;
    bus.in_valid = vld; bus.in_instr = instr; bus.in_last = last;
    bus.dma_full_soon = dfs; bus.arith_full_soon = afs; bus.cache_full_soon = cfs;
    #1;
    ed = '0; ea = '0; ec = '0;
    if (rst_in) begin
      er = 1'b0; ew = 1'b0; ewc = 2'd0;
    end else begin
      er  = !m_flush;
      ew  = m_flush && !(dfs | afs | cfs);
      ewc = ew ? 2'(grp.size() - 1) : 2'd0;
      foreach (grp[k]) begin
        ed[78*k +: 78] = grp[k][95:18];
        ea[k]          = grp[k][17];
        ec[17*k +: 17] = grp[k][16:0];
      end
    end
    o_ready = bus.in_ready; o_we = bus.q_we; o_wec = bus.q_we_count;
    o_dma = bus.dma_dat_w; o_ar = bus.arith_dat_w; o_ca = bus.cache_dat_w;
    chk("in_ready", 512'(o_ready), 512'(er));
    chk("q_we", 512'(o_we), 512'(ew));
    chk("q_we_count", 512'(o_wec), 512'(ewc));
    chk("dma_dat_w", 512'(o_dma), 512'(ed));
    chk("arith_dat_w", 512'(o_ar), 512'(ea));
    chk("cache_dat_w", 512'(o_ca), 512'(ec));
    // advance the model to the state after this edge
    if (rst_in) begin
      grp.delete(); m_idle = 0; m_flush = 0;
    end else if (m_flush) begin
      if (ew) begin grp.delete(); m_idle = 0; m_flush = 0; end
    end else if (vld) begin
      if (is_bubble(instr)) begin
        if (last && grp.size() > 0) m_flush = 1;
      end else begin
        grp.push_back(instr);
        m_idle = 0;
        if (grp.size() == 4 || last) m_flush = 1;
      end
    end else if (grp.size() > 0) begin
      m_idle++;
      if (m_idle == TIMEOUT) m_flush = 1;
    end
    @(posedge clk);
  endtask

  task automatic send(input logic [95:0] b, input logic l);
    vld = 1'b1; instr = b; last = l;
    step();
    vld = 1'b0; last = 1'b0;
  endtask

  task automatic idle_cyc();
    vld = 1'b0; last = 1'b0;
    step();
  endtask

  function automatic logic [95:0] mk(input int d);
    logic [95:0] b;
    b = '0;
    b[95:18] = 78'(d);
    b[17] = 1'b1;
    return b;
  endfunction

  initial begin
    logic [311:0] held;
    logic [95:0]  r;
    vld = 0; last = 0; dfs = 0; afs = 0; cfs = 0; instr = '0; rst_in = 1'b1;
    grp.delete(); m_idle = 0; m_flush = 0;
    step(); step();
    rst_in = 1'b0;

    // four consecutive bundles -> one write, slots 1..4
    for (int k = 0; k < 4; k++) send(mk(k + 1), 1'b0);
    idle_cyc();
    chk("g4_we", 512'(o_we), 512'(1));
    chk("g4_count", 512'(o_wec), 512'(3));
    chk("g4_ready", 512'(o_ready), 512'(0));
    for (int k = 0; k < 4; k++) chk("g4_slot", 512'(o_dma[78*k +: 78]), 512'(k + 1));

    // two bundles closed by in_last
    send(mk(7), 1'b0);
    send(mk(8), 1'b1);
    idle_cyc();
    chk("g2_count", 512'(o_wec), 512'(1));
    chk("g2_hi_dma", 512'(o_dma[311:156]), 512'(0));
    chk("g2_hi_cache", 512'(o_ca[67:34]), 512'(0));
    idle_cyc();
    chk("g2_ready_after", 512'(o_ready), 512'(1));

    // timeout flush on the 9th cycle after the accept
    send(mk(9), 1'b0);
    for (int i = 1; i <= TIMEOUT; i++) begin
      idle_cyc();
      chk("to_quiet", 512'(o_we), 512'(0));
    end
    idle_cyc();
    chk("to_we", 512'(o_we), 512'(1));
    chk("to_count", 512'(o_wec), 512'(0));

    // five-cycle cache backpressure stall
    for (int k = 0; k < 4; k++) send(mk(20 + k), 1'b0);
    cfs = 1'b1;
    for (int i = 0; i < 5; i++) begin
      idle_cyc();
      if (i == 0) held = o_dma;
      chk("stall_we", 512'(o_we), 512'(0));
      chk("stall_ready", 512'(o_ready), 512'(0));
    end
    cfs = 1'b0;
    idle_cyc();
    chk("stall_release_we", 512'(o_we), 512'(1));
    chk("stall_data_held", 512'(o_dma), 512'(held));

    // active, bubble, active, bubble+last
    send(mk(30), 1'b0);
    send(96'h0, 1'b0);
    send(mk(31), 1'b0);
    send(96'h0, 1'b1);
`ifndef DISPATCH_SQUASH_EN
    // without squash the 4th bundle fills the group
`endif
    idle_cyc();
`ifdef DISPATCH_SQUASH_EN
    chk("squash_count", 512'(o_wec), 512'(1));
    chk("squash_slot1", 512'(o_dma[155:78]), 512'(31));
`else
    chk("nosquash_count", 512'(o_wec), 512'(3));
    chk("nosquash_slot2", 512'(o_dma[233:156]), 512'(31));
`endif

    // reset during a WRITE stall drops the group
    for (int k = 0; k < 4; k++) send(mk(40 + k), 1'b0);
    dfs = 1'b1;
    idle_cyc();
    dfs = 1'b0; rst_in = 1'b1;
    idle_cyc();
    chk("rst_no_we", 512'(o_we), 512'(0));
    rst_in = 1'b0;
    idle_cyc();
    chk("rst_ready", 512'(o_ready), 512'(1));
    chk("rst_quiet", 512'(o_we), 512'(0));
    send(mk(50), 1'b1);
    idle_cyc();
    chk("rst_single_count", 512'(o_wec), 512'(0));
    chk("rst_single_we", 512'(o_we), 512'(1));

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      r = {$urandom, $urandom, $urandom};
      if ($urandom_range(3) == 0) begin r[95] = 1'b0; r[17] = 1'b0; r[16] = 1'b0; end
      instr  = r;
      vld    = ($urandom_range(9) < 7);
      last   = ($urandom_range(99) < 15);
      dfs    = ($urandom_range(9) == 0);
      afs    = ($urandom_range(9) == 0);
      cfs    = ($urandom_range(9) == 0);
      rst_in = ($urandom_range(199) == 0);
      step();
    end
    vld = 0; last = 0; dfs = 0; afs = 0; cfs = 0; rst_in = 0;
    for (int i = 0; i < TIMEOUT + 4; i++) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
